// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per clock,
// most significant chunk first, and stops at the first chunk that differs.
module chunked_comparator #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int NCHUNK = WIDTH / CHUNK,
  parameter int SW     = $clog2(NCHUNK + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          less,
  output logic          greater,
  output logic          equal,
  output logic [SW-1:0] steps
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0]    TOP_IDX  = IW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             less_q, less_d, greater_q, greater_d, equal_q, equal_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;

  // Flipping the MSB of the top chunk maps two's-complement order onto unsigned order.
  always_comb begin
    chunk_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    chunk_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
    if (signed_q && (idx_q == TOP_IDX)) begin
      chunk_a = chunk_a ^ MSB_MASK;
      chunk_b = chunk_b ^ MSB_MASK;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    less_d    = less_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    steps_d   = steps_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          idx_d    = TOP_IDX;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + SW'(1);
        if (chunk_a != chunk_b) begin
          less_d    = (chunk_a < chunk_b);
          greater_d = (chunk_a > chunk_b);
          equal_d   = 1'b0;
          steps_d   = cnt_q + SW'(1);
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (idx_q == '0) begin
          less_d    = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b1;
          steps_d   = SW'(NCHUNK);
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= TOP_IDX;
      cnt_q     <= '0;
      less_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      steps_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      less_q    <= less_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
      steps_q   <= steps_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign less    = less_q;
  assign greater = greater_q;
  assign equal   = equal_q;
  assign steps   = steps_q;

endmodule
